// File: rtl/ser_link_pkg.sv
// Shared serial-link definitions used by both the transmitter and receiver sides.
package ser_link_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} deser_state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/deser_out_buffer.sv
// Single-entry valid/ready holding register for assembled words.
module deser_out_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_accept,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  input  logic             i_ready
);
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             w_full;
  logic             w_accept;

  // Full only when the held word is not drained this cycle.
  assign w_full   = r_valid & ~i_ready;
  assign w_accept = i_load & ~w_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) r_word <= i_data;
      r_valid <= w_accept | w_full;
    end
  end

  assign o_full   = w_full;
  assign o_accept = w_accept;
  assign o_word   = r_word;
  assign o_valid  = r_valid;
endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit frames LSB- or MSB-first into a
// valid/ready output buffer, with sticky overrun and frame-error flags.
module serial_word_deserializer
  import ser_link_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  deser_state_t     r_state, w_state_next;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_frame_dir;
  logic             r_overrun;
  logic             r_frame_err;

  logic             w_frame_start;
  logic             w_shift;
  logic             w_complete;
  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] w_sr_first;
  logic             w_buf_full;
  logic             w_buf_accept;

  assign w_frame_start = ser_valid & start;
  assign w_shift       = (r_state == SHIFT) & ser_valid & ~start;
  assign w_complete    = w_shift & (r_cnt == LAST_CNT);

  assign w_sr_shift = (r_frame_dir == DIR_MSB_FIRST) ? {r_sr[WIDTH-2:0], ser_in}
                                                     : {ser_in, r_sr[WIDTH-1:1]};
  // A start bit always begins from a clean register, discarding any partial frame.
  assign w_sr_first = (dir == DIR_LSB_FIRST) ? {ser_in, {(WIDTH-1){1'b0}}}
                                             : {{(WIDTH-1){1'b0}}, ser_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_frame_start) w_state_next = SHIFT;
      SHIFT:   if (w_complete)    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr        <= '0;
      r_cnt       <= '0;
      r_frame_dir <= DIR_LSB_FIRST;
    end else if (w_frame_start) begin
      r_sr        <= w_sr_first;
      r_cnt       <= CW'(1);
      r_frame_dir <= dir;
    end else if (w_shift) begin
      r_sr  <= w_sr_shift;
      r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_complete & w_buf_full)                   r_overrun <= 1'b1;
      else if (clr_err)                              r_overrun <= 1'b0;
      if ((r_state == SHIFT) & w_frame_start)        r_frame_err <= 1'b1;
      else if (clr_err)                              r_frame_err <= 1'b0;
    end
  end

  deser_out_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_complete),
    .i_data   (w_sr_shift),
    .o_full   (w_buf_full),
    .o_accept (w_buf_accept),
    .o_word   (word_out),
    .o_valid  (word_valid),
    .i_ready  (word_ready)
  );

  logic w_unused;
  assign w_unused = w_buf_accept;

  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (WIDTH=8) with immediate assertions.
module tb_serial_word_deserializer;
  logic       clk = 1'b0;
  logic       rst;
  logic       dir, ser_in, ser_valid, start, word_ready, clr_err;
  logic [7:0] word_out;
  logic       word_valid, busy, overrun, frame_err;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  serial_word_deserializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dir        (dir),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .start      (start),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one frame; bit order follows d. Inputs change just after negedge.
  task automatic send_frame(input logic [7:0] w, input logic d, input bit gaps,
                            input bit toggle, input bit clr_last, input bit chk_lat);
    dir = d;
    for (int i = 0; i < 8; i++) begin
      ser_in    = d ? w[7-i] : w[i];
      ser_valid = 1'b1;
      start     = (i == 0);
      if (toggle && i == 4) dir = ~dir;
      if (clr_last && i == 7) clr_err = 1'b1;
      @(negedge clk);
      ser_valid = 1'b0;
      start     = 1'b0;
      clr_err   = 1'b0;
      if (i == 3) chk("busy_mid", busy, 1);
      if (chk_lat && i == 6) chk("no_early_valid", word_valid, 0);
      if (gaps && i < 7) repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; dir = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; start = 1'b0;
    word_ready = 1'b1; clr_err = 1'b0;
    #1;
    chk("rst_word", word_out, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overrun, frame_err}, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // T1: LSB-first 1,0,1,1,0,0,1,0
    send_frame(8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_valid", word_valid, 1);
    chk("t1_word", word_out, 8'h4D);
    chk("t1_busy", busy, 0);
    @(negedge clk);
    chk("t1_valid_one_cycle", word_valid, 0);

    // T2: MSB-first, then with dir toggled mid-frame
    send_frame(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_word", word_out, 8'hB2);
    chk("t2_valid", word_valid, 1);
    @(negedge clk);
    send_frame(8'hB2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_toggle_word", word_out, 8'hB2);
    @(negedge clk);

    // T3: back-to-back frames with consumer stalled
    word_ready = 1'b0;
    send_frame(8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_first_valid", word_valid, 1);
    chk("t3_no_overrun_yet", overrun, 0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_word_held", word_out, 8'h4D);
    chk("t3_overrun", overrun, 1);
    chk("t3_still_valid", word_valid, 1);
    word_ready = 1'b1;
    @(negedge clk);
    chk("t3_drained", word_valid, 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t3_clr_overrun", overrun, 0);

    // T4: random gaps between bits
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_word", word_out, 8'hA5);
    chk("t4_valid", word_valid, 1);
    @(negedge clk);

    // T5: start re-asserted after 3 bits
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser_in = 1'b1; ser_valid = 1'b1; start = (i == 0);
      @(negedge clk);
    end
    ser_valid = 1'b0; start = 1'b0;
    chk("t5_partial_busy", busy, 1);
    chk("t5_no_err_yet", frame_err, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_frame_err", frame_err, 1);
    chk("t5_word", word_out, 8'h3C);
    chk("t5_valid", word_valid, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t5_clr_frame_err", frame_err, 0);

    // T6: set-wins on clr_err, then async reset mid-frame
    word_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_set_wins", overrun, 1);
    chk("t6_word_held", word_out, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      ser_in = 1'b1; ser_valid = 1'b1; start = (i == 0);
      @(negedge clk);
    end
    ser_valid = 1'b0; start = 1'b0;
    chk("t6_busy_pre_rst", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_word", word_out, 0);
    chk("t6_rst_valid", word_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_flags", {overrun, frame_err}, 0);
    @(negedge clk); rst = 1'b1;
    word_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ser_in = 1'($urandom_range(0, 1)); ser_valid = 1'b1; start = 1'b0;
      @(negedge clk);
    end
    ser_valid = 1'b0;
    @(negedge clk);
    chk("t6_no_word", word_valid, 0);
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
